// File: rtl/issue_scoreboard_pkg.sv
// issue_pkg: shared types for the issue scoreboard (FSM state, register index width, issued-instruction record).
`default_nettype none

package issue_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } iss_state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 wr_rd;
  } iss_instr_t;

endpackage

`default_nettype wire

// File: rtl/issue_scoreboard_pending_tbl.sv
// issue_pending_tbl: per-GPR pending bits with set/clear ports and the RAW/WAW hazard check.
// Optional ISSUE_WB_BYPASS_EN: a same-cycle clear masks its pending bit in the hazard check.
`default_nettype none

module issue_pending_tbl
  import issue_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic [REG_IDX_W-1:0] i_rs1_idx,
  input  logic [REG_IDX_W-1:0] i_rs2_idx,
  input  logic [REG_IDX_W-1:0] i_rd_idx,
  input  logic                 i_use_rs1,
  input  logic                 i_use_rs2,
  input  logic                 i_wr_rd,
  output logic                 o_hazard
);

  localparam int SPACE = 1 << REG_IDX_W;

  logic [NUM_REGS-1:0] r_pending;
  logic [SPACE-1:0]    w_set_mask;
  logic [SPACE-1:0]    w_clr_mask;
  logic [SPACE-1:0]    w_byp_mask;
  logic [SPACE-1:0]    w_view;

  assign w_set_mask = SPACE'(i_set_en) << i_set_idx;
  assign w_clr_mask = SPACE'(i_clr_en) << i_clr_idx;

`ifdef ISSUE_WB_BYPASS_EN
  assign w_byp_mask = w_clr_mask;
`else
  assign w_byp_mask = '0;
`endif

  // Bit 0 is x0 and is forced clear both in storage and in the view.
  assign w_view   = SPACE'(r_pending) & ~w_byp_mask & ~SPACE'(1);
  assign o_hazard = (i_use_rs1 & w_view[i_rs1_idx]) |
                    (i_use_rs2 & w_view[i_rs2_idx]) |
                    (i_wr_rd   & w_view[i_rd_idx]);

  // Set after clear so that a same-register set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask[NUM_REGS-1:0]) | w_set_mask[NUM_REGS-1:0])
                   & ~NUM_REGS'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-to-execute issue register with GPR scoreboard, inflight counter and EMPTY/HOLD/STALL FSM.
// Optional ISSUE_WB_BYPASS_EN (in issue_pending_tbl): writeback bypass into the hazard check.
`default_nettype none

module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int NUM_REGS     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1_idx,
  input  logic [REG_IDX_W-1:0] dec_rs2_idx,
  input  logic [REG_IDX_W-1:0] dec_rd_idx,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic                 dec_wr_rd,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [REG_IDX_W-1:0] iss_rd_idx,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd_idx,
  input  logic                 flush,
  output logic [3:0]           inflight_cnt
);

  iss_state_t r_state;
  iss_instr_t r_instr;
  logic       r_iss_valid;
  logic [3:0] r_cnt;

  logic w_issue;
  logic w_wb;
  logic w_hazard;
  logic w_room;
  logic w_slot_free;
  logic w_ready;
  logic w_accept;
  logic w_set_en;

  assign w_issue  = r_iss_valid & iss_ready;
  assign w_wb     = wb_valid & (r_cnt != 4'd0);
  assign w_set_en = w_issue & r_instr.wr_rd & (r_instr.rd_idx != '0);

  // The held instruction is counted against the limit: it issues in the
  // same cycle a new one is accepted, so the counter never exceeds the cap.
  assign w_room      = ({1'b0, r_cnt} + {4'b0, r_iss_valid}) < 5'(MAX_INFLIGHT);
  assign w_slot_free = (r_state != HOLD) | iss_ready;
  assign w_ready     = reset_n & ~flush & w_slot_free & ~w_hazard & w_room;
  assign w_accept    = dec_valid & w_ready;

  assign dec_ready    = w_ready;
  assign iss_valid    = r_iss_valid;
  assign iss_rd_idx   = r_instr.rd_idx;
  assign inflight_cnt = r_cnt;

  issue_pending_tbl #(
    .NUM_REGS (NUM_REGS)
  ) u_pending_tbl (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_set_en  (w_set_en),
    .i_set_idx (r_instr.rd_idx),
    .i_clr_en  (w_wb),
    .i_clr_idx (wb_rd_idx),
    .i_rs1_idx (dec_rs1_idx),
    .i_rs2_idx (dec_rs2_idx),
    .i_rd_idx  (dec_rd_idx),
    .i_use_rs1 (dec_use_rs1),
    .i_use_rs2 (dec_use_rs2),
    .i_wr_rd   (dec_wr_rd),
    .o_hazard  (w_hazard)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_iss_valid <= 1'b0;
      r_instr     <= '0;
      r_cnt       <= 4'd0;
    end else begin
      // An issue coinciding with flush still counts: execute already took it.
      r_cnt <= r_cnt + 4'(w_issue) - 4'(w_wb);
      if (flush) begin
        r_state     <= EMPTY;
        r_iss_valid <= 1'b0;
      end else if (w_accept) begin
        r_state     <= HOLD;
        r_iss_valid <= 1'b1;
        r_instr     <= '{rd_idx: dec_rd_idx, wr_rd: dec_wr_rd};
      end else begin
        case (r_state)
          HOLD: begin
            if (iss_ready) begin
              r_iss_valid <= 1'b0;
              r_state     <= dec_valid ? STALL : EMPTY;
            end
          end
          EMPTY: begin
            if (dec_valid) r_state <= STALL;
          end
          STALL: begin
            if (!dec_valid) r_state <= EMPTY;
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// Randomized bench for issue_scoreboard against a queue/array reference model of the scoreboard rules.
`default_nettype none

module tb_issue_scoreboard;

  localparam int MAXI = 4;
  localparam int NR   = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_ready;
  logic [4:0] dec_rs1_idx = '0, dec_rs2_idx = '0, dec_rd_idx = '0;
  logic       dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0, dec_wr_rd = 1'b0;
  logic       iss_valid;
  logic       iss_ready = 1'b0;
  logic [4:0] iss_rd_idx;
  logic       wb_valid = 1'b0;
  logic [4:0] wb_rd_idx = '0;
  logic       flush = 1'b0;
  logic [3:0] inflight_cnt;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI), .NUM_REGS(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_idx(dec_rs1_idx), .dec_rs2_idx(dec_rs2_idx), .dec_rd_idx(dec_rd_idx),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd_idx(iss_rd_idx),
    .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx), .flush(flush),
    .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: set of pending registers, number of issued-not-written-back,
  // and the one instruction (if any) sitting in the issue register.
  bit m_pend[NR];
  int m_cnt;
  bit m_hv;
  int m_hrd;
  bit m_hwr;

  function automatic bit busy(input int r);
    if (r == 0) return 1'b0;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_valid && m_cnt > 0 && int'(wb_rd_idx) == r) return 1'b0;
`endif
    return m_pend[r];
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = (dec_use_rs1 && busy(int'(dec_rs1_idx))) ||
          (dec_use_rs2 && busy(int'(dec_rs2_idx))) ||
          (dec_wr_rd   && busy(int'(dec_rd_idx)));
    return reset_n && !flush && (!m_hv || iss_ready) && !haz && (m_cnt + int'(m_hv) < MAXI);
  endfunction

  task automatic model_clear();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt = 0; m_hv = 1'b0; m_hrd = 0; m_hwr = 1'b0;
  endtask

  // Called at posedge+1: drive, check at negedge, advance model at posedge.
  task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                      input bit u1, input bit u2, input bit w, input bit irdy,
                      input bit wbv, input int wbrd, input bit fl);
    bit exp_rdy, acc, issue, wbe;
    dec_valid = v; dec_rs1_idx = 5'(rs1); dec_rs2_idx = 5'(rs2); dec_rd_idx = 5'(rd);
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = w;
    iss_ready = irdy; wb_valid = wbv; wb_rd_idx = 5'(wbrd); flush = fl;
    @(negedge clk);
    exp_rdy = m_ready();
    chk("dec_ready", 32'(dec_ready), 32'(exp_rdy));
    chk("iss_valid", 32'(iss_valid), 32'(m_hv));
    if (m_hv) chk("iss_rd_idx", 32'(iss_rd_idx), 32'(m_hrd));
    chk("inflight_cnt", 32'(inflight_cnt), 32'(m_cnt));
    acc = v && exp_rdy;
    @(posedge clk);
    issue = m_hv && irdy;
    wbe   = wbv && m_cnt > 0;
    if (wbe) m_pend[wbrd] = 1'b0;
    if (issue && m_hwr && m_hrd != 0) m_pend[m_hrd] = 1'b1;
    m_cnt = m_cnt + int'(issue) - int'(wbe);
    if (fl) m_hv = 1'b0;
    else if (acc) begin m_hv = 1'b1; m_hrd = rd; m_hwr = w; end
    else if (issue) m_hv = 1'b0;
    #1;
  endtask

  task automatic idle(input bit irdy);
    step(0, 0, 0, 0, 0, 0, 0, irdy, 0, 0, 0);
  endtask

  task automatic wb(input int r);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, r, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dec_valid = 1'b1; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_wr_rd = 1'b0;
    iss_ready = 1'b1; wb_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rst_dec_ready", 32'(dec_ready), 32'd0);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_iss_rd_idx", 32'(iss_rd_idx), 32'd0);
    chk("rst_inflight", 32'(inflight_cnt), 32'd0);
    @(posedge clk);
    model_clear();
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int pl[$];
    int wbrd;
    model_clear();
    #1;
    do_reset();

    // Back-to-back independent instructions, first one in the first cycle after reset.
    step(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 3, 4, 2, 1, 1, 1, 1, 0, 0, 0);
    idle(1); idle(1);
    wb(1); wb(2);

    // RAW on x5: dependent decode held until writeback.
    step(1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    repeat (3) step(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0);
    step(1, 5, 0, 6, 1, 0, 1, 1, 1, 5, 0);
    step(1, 5, 0, 6, 1, 0, 1, 1, 0, 0, 0);
    idle(1); wb(6); idle(1);

    // Inflight limit then one writeback.
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 10 + i, 0, 0, 1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 15, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 15, 0, 0, 1, 1, 1, 11, 0);
    step(1, 0, 0, 15, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    for (int i = 12; i <= 15; i++) wb(i);

    // Backpressure then flush.
    step(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 8, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);

    // x0 never stalls; writeback with empty counter is ignored.
    repeat (3) step(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    idle(1);
    repeat (6) wb(0);
    step(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    idle(1);
    repeat (2) wb(0);

    // Reset in the middle of HOLD.
    step(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0);
    idle(0);
    do_reset();
    step(1, 9, 9, 9, 1, 1, 1, 1, 0, 0, 0);
    idle(1);
    wb(9);

    // Randomized traffic on a narrow register window to provoke hazards.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        pl.delete();
        for (int r = 0; r < NR; r++) if (m_pend[r]) pl.push_back(r);
        if (pl.size() > 0 && $urandom_range(0, 3) != 0)
          wbrd = pl[$urandom_range(0, pl.size() - 1)];
        else
          wbrd = $urandom_range(0, 7);
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, wbrd,
             $urandom_range(0, 31) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, giving the maximum number of issued instructions without writeback (legal range 1..15).
REQ-002 SHALL have parameter NUM_REGS, default 32, giving the number of architectural GPRs; index 0 is hard-wired zero.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 dec_valid  in  1  decode presents an instruction.
REQ-006 dec_ready  out  1  scoreboard accepts the decoded instruction this cycle.
REQ-007 dec_rs1_idx, dec_rs2_idx, dec_rd_idx  in  5 each  source and destination register indices.
REQ-008 dec_use_rs1, dec_use_rs2, dec_wr_rd  in  1 each  operand-use and destination-write flags.
REQ-009 iss_valid  out  1  the issue register holds an instruction for execute.
REQ-010 iss_ready  in  1  execute accepts the instruction.
REQ-011 iss_rd_idx  out  5  destination index of the held instruction.
REQ-012 wb_valid  in  1  writeback retires one destination.
REQ-013 wb_rd_idx  in  5  index of the retiring destination.
REQ-014 flush  in  1  branch redirect; drops the held and not-yet-issued instruction.
REQ-015 inflight_cnt  out  4  count of issued instructions without writeback.

Function
REQ-016 SHALL keep a pending bit per GPR; bit 0 SHALL always read 0.
REQ-017 Hazard SHALL be (dec_use_rs1 & pending[rs1]) | (dec_use_rs2 & pending[rs2]) | (dec_wr_rd & pending[rd]), covering RAW and WAW.
REQ-018 The FSM SHALL have states EMPTY (issue register free), HOLD (instruction waiting for iss_ready) and STALL (dec_valid with hazard or inflight_cnt==MAX_INFLIGHT).
REQ-019 dec_ready SHALL be 1 when there is no hazard, inflight_cnt<MAX_INFLIGHT, flush=0, and the state is EMPTY or (HOLD with iss_ready=1).
REQ-020 Acceptance (dec_valid&dec_ready) SHALL load the issue register, giving iss_valid=1 on the next cycle (latency 1).
REQ-021 Issue (iss_valid&iss_ready) SHALL set pending[iss_rd_idx] when wr_rd and rd!=0, and SHALL increment inflight_cnt.
REQ-022 wb_valid SHALL clear pending[wb_rd_idx] and decrement inflight_cnt.
REQ-023 Issue and writeback in the same cycle SHALL leave inflight_cnt unchanged.
REQ-024 When both target the same register, set SHALL win.
REQ-025 wb_valid with inflight_cnt==0 SHALL be ignored; the counter SHALL NOT underflow.
REQ-026 Transitions:
- EMPTY->HOLD on accept.
- HOLD->EMPTY on issue without accept.
- HOLD->HOLD on issue with accept.
- EMPTY/HOLD->STALL when dec_valid and blocked, with the issue register empty.
- STALL->HOLD on accept.
- STALL->EMPTY when dec_valid drops.
REQ-027 flush SHALL clear iss_valid and force EMPTY next cycle.
REQ-028 flush SHALL NOT alter pending bits or inflight_cnt of already-issued instructions.
REQ-029 flush coincident with issue SHALL still count the issue, because execute has accepted it.
REQ-030 iss_valid and iss_rd_idx SHALL hold stable while iss_valid=1 and iss_ready=0.

Reset
REQ-031 While reset_n=0, state SHALL be EMPTY, all pending bits 0, inflight_cnt 0, iss_valid 0, iss_rd_idx 0 and dec_ready 0.
REQ-032 Reset asserted mid-HOLD SHALL discard the held instruction with no side effect.
REQ-033 The first accept SHALL be possible in the first cycle after reset_n rises.

Configuration
REQ-034 Macro ISSUE_WB_BYPASS_EN SHALL control writeback bypass into the hazard check.
REQ-035 With ISSUE_WB_BYPASS_EN defined, a same-cycle wb_valid for a register SHALL mask that register's pending bit in the hazard check, so a dependent instruction is accepted in the writeback cycle.
REQ-036 Without ISSUE_WB_BYPASS_EN, the hazard check SHALL use registered pending bits only, so a dependent instruction is accepted one cycle after writeback.

Structure
REQ-037 Package issue_pkg SHALL hold the FSM state enum (EMPTY, HOLD, STALL), the REG_IDX_W=5 constant and the issued-instruction typedef (rd_idx, wr_rd).
REQ-038 One sub-module, issue_pending_tbl, SHALL hold the pending bit vector with set/clear ports and two-read/one-check hazard logic; the FSM and counter SHALL stay in the top module.

Verification
REQ-039 Back-to-back independent: `add x1` then `add x2,x3,x4` with iss_ready=1 -> both accepted on consecutive cycles, inflight_cnt reaches 2.
REQ-040 RAW: issue rd=x5, then decode with rs1=x5 -> dec_ready=0 until wb_valid with wb_rd_idx=5; accept in that cycle with the macro defined, one cycle later without it.
REQ-041 Limit: MAX_INFLIGHT=4, four issues and no writeback -> fifth decode stalls; one wb_valid -> accepted next cycle.
REQ-042 Backpressure and flush: iss_ready=0 for 3 cycles -> iss_valid and iss_rd_idx stable; flush -> iss_valid=0 next cycle, inflight_cnt unchanged.
REQ-043 x0 and counter edge cases: decode with rd=x0 and rs1=x0 -> never stalls and pending stays 0; wb_valid with inflight_cnt=0 -> count stays 0.
REQ-044 Reset mid-HOLD: reset_n low for 1 cycle -> all outputs at reset values, pending table cleared.
